// File: rtl/i2c_target_ctrl.sv
// rtl/i2c_target_ctrl.sv - I2C target bridging 16-bit sub-address frames to register strobes
// Oversampled SCL/SDA, open-drain SDA output, auto-incrementing register pointer.
module i2c_target_ctrl #(
   parameter logic [6:0] DEV_ADDR = 7'h1A,
   parameter int         SYNC     = 2
) (
   input  logic        I2C_clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        rd_req,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        busy,
   output logic        nack_err
);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] DEVADDR   = 4'd1;
   localparam logic [3:0] ACK_DEV   = 4'd2;
   localparam logic [3:0] SUBH      = 4'd3;
   localparam logic [3:0] ACK_SUBH  = 4'd4;
   localparam logic [3:0] SUBL      = 4'd5;
   localparam logic [3:0] ACK_SUBL  = 4'd6;
   localparam logic [3:0] WDATA     = 4'd7;
   localparam logic [3:0] ACK_WDATA = 4'd8;
   localparam logic [3:0] RDATA     = 4'd9;
   localparam logic [3:0] MACK      = 4'd10;
   localparam logic [3:0] WAIT_STOP = 4'd11;

   logic [SYNC-1:0] scl_sync;
   logic [SYNC-1:0] sda_sync;
   logic            scl_d;
   logic            sda_d;
   logic            scl_s;
   logic            sda_s;
   logic            scl_rise;
   logic            scl_fall;
   logic            start_det;
   logic            stop_det;

   logic [3:0]      state;
   logic [2:0]      bit_cnt;
   logic            byte_done;
   logic            byte_end;
   logic            rx_state;
   logic [7:0]      shift;
   logic [15:0]     ptr;
   logic            rw;
   logic            rd_cap;
   logic [7:0]      rd_buf;

   // Synchronisers idle high so that reset never fakes a bus edge.
   always_ff @(posedge I2C_clk) begin
      if (reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC-2:0], sda_in};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC-1];
   assign sda_s     = sda_sync[SYNC-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & sda_d & ~sda_s;
   assign stop_det  = scl_s & ~sda_d & sda_s;
   assign byte_end  = scl_fall & byte_done;
   assign rx_state  = (state == DEVADDR) || (state == SUBH) ||
                      (state == SUBL) || (state == WDATA);

   always_ff @(posedge I2C_clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         byte_done <= 1'b0;
         shift     <= 8'h00;
         ptr       <= 16'h0000;
         rw        <= 1'b0;
         rd_cap    <= 1'b0;
         rd_buf    <= 8'h00;
         sda_oe    <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= 16'h0000;
         wr_data   <= 8'h00;
         rd_req    <= 1'b0;
         rd_addr   <= 16'h0000;
         busy      <= 1'b0;
         nack_err  <= 1'b0;
      end else begin
         wr_en    <= 1'b0;
         rd_req   <= 1'b0;
         nack_err <= 1'b0;
         rd_cap   <= rd_req;
         if (rd_cap)
            rd_buf <= rd_data;
         if (wr_en)
            ptr <= ptr + 16'd1;

         if (start_det) begin
            state     <= DEVADDR;
            busy      <= 1'b1;
            sda_oe    <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
         end else if (stop_det) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sda_oe    <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
         end else begin
            if (rx_state && scl_rise && !byte_done) begin
               shift   <= {shift[6:0], sda_s};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  byte_done <= 1'b1;
            end
            if (rx_state && byte_end) begin
               byte_done <= 1'b0;
               bit_cnt   <= 3'd0;
            end

            case (state)
               IDLE: ;
               DEVADDR:
                  if (byte_end) begin
                     if (shift[7:1] == DEV_ADDR) begin
                        rw     <= shift[0];
                        sda_oe <= 1'b1;
                        state  <= ACK_DEV;
                     end else begin
                        nack_err <= 1'b1;
                        state    <= WAIT_STOP;
                     end
                  end
               ACK_DEV: begin
                  if (scl_rise && rw) begin
                     rd_req  <= 1'b1;
                     rd_addr <= ptr;
                  end
                  if (scl_fall) begin
                     if (rw) begin
                        shift  <= rd_buf;
                        sda_oe <= ~rd_buf[7];
                        state  <= RDATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= SUBH;
                     end
                  end
               end
               SUBH:
                  if (byte_end) begin
                     ptr[15:8] <= shift;
                     sda_oe    <= 1'b1;
                     state     <= ACK_SUBH;
                  end
               ACK_SUBH:
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= SUBL;
                  end
               SUBL:
                  if (byte_end) begin
                     ptr[7:0] <= shift;
                     sda_oe   <= 1'b1;
                     state    <= ACK_SUBL;
                  end
               ACK_SUBL:
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= WDATA;
                  end
               WDATA:
                  if (byte_end) begin
                     wr_en   <= 1'b1;
                     wr_addr <= ptr;
                     wr_data <= shift;
                     sda_oe  <= 1'b1;
                     state   <= ACK_WDATA;
                  end
               ACK_WDATA:
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= WDATA;
                  end
               RDATA: begin
                  if (scl_rise && !byte_done) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        byte_done <= 1'b1;
                  end else if (scl_fall) begin
                     if (byte_done) begin
                        sda_oe    <= 1'b0;
                        byte_done <= 1'b0;
                        bit_cnt   <= 3'd0;
                        state     <= MACK;
                     end else begin
                        shift  <= {shift[6:0], 1'b0};
                        sda_oe <= ~shift[6];
                     end
                  end
               end
               // byte_done here means the master ACKed and the next byte is on its way.
               MACK: begin
                  if (scl_rise && !byte_done) begin
                     ptr <= ptr + 16'd1;
                     if (sda_s) begin
                        nack_err <= 1'b1;
                        state    <= WAIT_STOP;
                     end else begin
                        rd_req    <= 1'b1;
                        rd_addr   <= ptr + 16'd1;
                        byte_done <= 1'b1;
                     end
                  end else if (byte_end) begin
                     byte_done <= 1'b0;
                     shift     <= rd_buf;
                     sda_oe    <= ~rd_buf[7];
                     state     <= RDATA;
                  end
               end
               WAIT_STOP:
                  sda_oe <= 1'b0;
               default:
                  state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// tb/tb_i2c_target_ctrl.sv - directed bench for i2c_target_ctrl
// Bit-banged I2C master on an open-drain bus with a small register-file read model.
module tb_i2c_target_ctrl;

   logic        I2C_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        scl_m   = 1'b1;
   logic        sda_m   = 1'b1;
   logic        scl_in;
   logic        sda_in;
   logic        sda_line;
   logic        sda_oe;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        rd_req;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic        busy;
   logic        nack_err;

   int checks = 0;
   int errors = 0;
   int qtr    = 8;

   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          nack_cnt = 0;
   int          oe_cnt = 0;
   logic [15:0] wr_a_log [64];
   logic [7:0]  wr_d_log [64];
   logic [15:0] rd_a_log [64];

   assign sda_line = sda_m & ~sda_oe;
   assign sda_in   = sda_line;
   assign scl_in   = scl_m;

   always #10 I2C_clk = ~I2C_clk;

   i2c_target_ctrl #(.DEV_ADDR(7'h1A), .SYNC(2)) dut (
      .I2C_clk  (I2C_clk),
      .reset    (reset),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda_oe   (sda_oe),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy),
      .nack_err (nack_err)
   );

   function automatic logic [7:0] reg_model(input logic [15:0] a);
      case (a)
         16'h0010: reg_model = 8'hC3;
         16'h0011: reg_model = 8'h3C;
         default:  reg_model = a[7:0] ^ 8'hA5;
      endcase
   endfunction

   always @(posedge I2C_clk)
      if (rd_req)
         rd_data <= reg_model(rd_addr);

   always @(negedge I2C_clk) begin
      if (wr_en) begin
         if (wr_cnt < 64) begin
            wr_a_log[wr_cnt] = wr_addr;
            wr_d_log[wr_cnt] = wr_data;
         end
         wr_cnt++;
      end
      if (rd_req) begin
         if (rd_cnt < 64)
            rd_a_log[rd_cnt] = rd_addr;
         rd_cnt++;
      end
      if (nack_err)
         nack_cnt++;
      if (sda_oe)
         oe_cnt++;
   end

   task automatic wait_q;
      repeat (qtr) @(negedge I2C_clk);
   endtask

   task automatic i2c_start;
      wait_q; sda_m = 1'b0;
      wait_q; scl_m = 1'b0;
   endtask

   task automatic i2c_rstart;
      wait_q; sda_m = 1'b1;
      wait_q; scl_m = 1'b1;
      wait_q; sda_m = 1'b0;
      wait_q; scl_m = 1'b0;
   endtask

   task automatic i2c_stop;
      wait_q; sda_m = 1'b0;
      wait_q; scl_m = 1'b1;
      wait_q; sda_m = 1'b1;
      wait_q;
   endtask

   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         wait_q; sda_m = b[i];
         wait_q; scl_m = 1'b1;
         wait_q;
         wait_q; scl_m = 1'b0;
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      send_bits(b);
      wait_q; sda_m = 1'b1;
      wait_q; scl_m = 1'b1;
      wait_q; ack = sda_line;
      wait_q; scl_m = 1'b0;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         wait_q; sda_m = 1'b1;
         wait_q; scl_m = 1'b1;
         wait_q; b[i] = sda_line;
         wait_q; scl_m = 1'b0;
      end
      wait_q; sda_m = nack;
      wait_q; scl_m = 1'b1;
      wait_q;
      wait_q; scl_m = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (5) @(negedge I2C_clk);
      reset = 1'b0;
      repeat (4) @(negedge I2C_clk);
      checks++;
      if ({sda_oe, wr_en, rd_req, busy, nack_err} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_ctrl got %b expected 00000", {sda_oe, wr_en, rd_req, busy, nack_err});
      end
      checks++;
      if ({wr_addr, wr_data, rd_addr} !== 40'h0) begin
         errors++;
         $display("FAIL reset_data got %h expected 0", {wr_addr, wr_data, rd_addr});
      end
   endtask

   task automatic test_basic_write;
      logic [7:0] fr [4];
      logic       ack;
      int         w0, n0;
      fr = '{8'h34, 8'h12, 8'h34, 8'h5A};
      qtr = 125;
      w0 = wr_cnt; n0 = nack_cnt;
      i2c_start;
      for (int i = 0; i < 4; i++) begin
         write_byte(fr[i], ack);
         checks++;
         if (ack !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack byte %0d got %b expected 0", i, ack);
         end
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_mid got %b expected 1", busy);
      end
      i2c_stop;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_end got %b expected 0", busy);
      end
      checks++;
      if (wr_cnt - w0 !== 1) begin
         errors++;
         $display("FAIL basic_wr_count got %0d expected 1", wr_cnt - w0);
      end else begin
         checks++;
         if (wr_a_log[w0] !== 16'h1234 || wr_d_log[w0] !== 8'h5A) begin
            errors++;
            $display("FAIL basic_wr got %h=%h expected 1234=5a", wr_a_log[w0], wr_d_log[w0]);
         end
      end
      checks++;
      if (nack_cnt - n0 !== 0) begin
         errors++;
         $display("FAIL basic_nack got %0d expected 0", nack_cnt - n0);
      end
      qtr = 8;
   endtask

   task automatic test_wrap;
      logic [7:0] fr [5];
      logic       ack;
      int         w0;
      fr = '{8'h34, 8'hFF, 8'hFF, 8'h11, 8'h22};
      w0 = wr_cnt;
      i2c_start;
      for (int i = 0; i < 5; i++) write_byte(fr[i], ack);
      i2c_stop;
      checks++;
      if (wr_cnt - w0 !== 2) begin
         errors++;
         $display("FAIL wrap_count got %0d expected 2", wr_cnt - w0);
      end else begin
         checks++;
         if (wr_a_log[w0] !== 16'hFFFF || wr_d_log[w0] !== 8'h11) begin
            errors++;
            $display("FAIL wrap_first got %h=%h expected ffff=11", wr_a_log[w0], wr_d_log[w0]);
         end
         checks++;
         if (wr_a_log[w0+1] !== 16'h0000 || wr_d_log[w0+1] !== 8'h22) begin
            errors++;
            $display("FAIL wrap_second got %h=%h expected 0000=22", wr_a_log[w0+1], wr_d_log[w0+1]);
         end
      end
   endtask

   task automatic test_read;
      logic       ack;
      logic [7:0] b0, b1;
      int         w0, r0, n0;
      w0 = wr_cnt; r0 = rd_cnt; n0 = nack_cnt;
      i2c_start;
      write_byte(8'h34, ack);
      write_byte(8'h00, ack);
      write_byte(8'h10, ack);
      i2c_rstart;
      write_byte(8'h35, ack);
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL read_dev_ack got %b expected 0", ack);
      end
      read_byte(1'b0, b0);
      read_byte(1'b1, b1);
      i2c_stop;
      checks++;
      if (b0 !== 8'hC3) begin
         errors++;
         $display("FAIL read_byte0 got %h expected c3", b0);
      end
      checks++;
      if (b1 !== 8'h3C) begin
         errors++;
         $display("FAIL read_byte1 got %h expected 3c", b1);
      end
      checks++;
      if (nack_cnt - n0 !== 1) begin
         errors++;
         $display("FAIL read_nack got %0d expected 1", nack_cnt - n0);
      end
      checks++;
      if (rd_cnt - r0 !== 2 || rd_a_log[r0] !== 16'h0010 || rd_a_log[r0+1] !== 16'h0011) begin
         errors++;
         $display("FAIL read_req got %0d reqs first %h expected 2 reqs 0010,0011", rd_cnt - r0, rd_a_log[r0]);
      end
      checks++;
      if (wr_cnt - w0 !== 0) begin
         errors++;
         $display("FAIL read_no_wr got %0d expected 0", wr_cnt - w0);
      end
   endtask

   task automatic test_mismatch;
      logic [7:0] fr [3];
      logic       ack;
      int         w0, n0, o0;
      fr = '{8'h56, 8'h12, 8'h34};
      w0 = wr_cnt; n0 = nack_cnt; o0 = oe_cnt;
      i2c_start;
      for (int i = 0; i < 3; i++) begin
         write_byte(fr[i], ack);
         checks++;
         if (ack !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_ack byte %0d got %b expected 1", i, ack);
         end
      end
      i2c_stop;
      checks++;
      if (oe_cnt - o0 !== 0) begin
         errors++;
         $display("FAIL mismatch_sda_driven got %0d cycles expected 0", oe_cnt - o0);
      end
      checks++;
      if (nack_cnt - n0 !== 1) begin
         errors++;
         $display("FAIL mismatch_nack got %0d expected 1", nack_cnt - n0);
      end
      checks++;
      if (wr_cnt - w0 !== 0) begin
         errors++;
         $display("FAIL mismatch_wr got %0d expected 0", wr_cnt - w0);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL mismatch_busy got %b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      logic       ack;
      logic [7:0] b;
      int         k, r0, w0;
      i2c_start;
      send_bits(8'h34);
      k = 0;
      while (sda_oe !== 1'b1 && k < 100) begin
         @(negedge I2C_clk);
         k++;
      end
      checks++;
      if (sda_oe !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_ack_drive got %b expected 1 within 100 cycles", sda_oe);
      end
      reset = 1'b1;
      @(negedge I2C_clk);
      reset = 1'b0;
      checks++;
      if (sda_oe !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_release got sda_oe=%b busy=%b expected 0 0", sda_oe, busy);
      end
      wait_q; sda_m = 1'b1;
      wait_q; scl_m = 1'b1;
      repeat (4) wait_q;
      r0 = rd_cnt;
      i2c_start;
      write_byte(8'h35, ack);
      read_byte(1'b1, b);
      i2c_stop;
      checks++;
      if (rd_cnt - r0 !== 1 || rd_a_log[r0] !== 16'h0000 || b !== 8'hA5) begin
         errors++;
         $display("FAIL rstmid_ptr got %0d reqs addr %h byte %h expected 1 req 0000 a5", rd_cnt - r0, rd_a_log[r0], b);
      end
      w0 = wr_cnt;
      i2c_start;
      write_byte(8'h34, ack);
      write_byte(8'h00, ack);
      write_byte(8'h05, ack);
      write_byte(8'h77, ack);
      i2c_stop;
      checks++;
      if (wr_cnt - w0 !== 1 || wr_a_log[w0] !== 16'h0005 || wr_d_log[w0] !== 8'h77) begin
         errors++;
         $display("FAIL rstmid_write got %0d writes %h=%h expected 1 write 0005=77", wr_cnt - w0, wr_a_log[w0], wr_d_log[w0]);
      end
   endtask

   task automatic test_stop_after_subh;
      logic       ack;
      logic [7:0] b;
      int         w0, r0;
      w0 = wr_cnt;
      i2c_start;
      write_byte(8'h34, ack);
      write_byte(8'h00, ack);
      write_byte(8'h00, ack);
      i2c_stop;
      i2c_start;
      write_byte(8'h34, ack);
      write_byte(8'hAB, ack);
      i2c_stop;
      checks++;
      if (wr_cnt - w0 !== 0) begin
         errors++;
         $display("FAIL subh_no_wr got %0d expected 0", wr_cnt - w0);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL subh_busy got %b expected 0", busy);
      end
      r0 = rd_cnt;
      i2c_start;
      write_byte(8'h35, ack);
      read_byte(1'b1, b);
      i2c_stop;
      checks++;
      if (rd_cnt - r0 !== 1 || rd_a_log[r0] !== 16'hAB00) begin
         errors++;
         $display("FAIL subh_rd_addr got %0d reqs addr %h expected 1 req ab00", rd_cnt - r0, rd_a_log[r0]);
      end
      checks++;
      if (b !== 8'hA5) begin
         errors++;
         $display("FAIL subh_rd_byte got %h expected a5", b);
      end
   endtask

   initial begin
      test_reset;
      test_basic_write;
      test_wrap;
      test_read;
      test_mismatch;
      test_reset_mid;
      test_stop_after_subh;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      repeat (200000) @(posedge I2C_clk);
      $display("FAIL watchdog expired after 200000 cycles, expected run to finish");
      $fatal(1, "watchdog");
   end

endmodule
